// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Purpose:
//   Valid/ready pipeline register between decode and execute. Carries the
//   destination register address and three decode control bits. A beat is
//   accepted on valid_IN && ready_OUT and presented downstream one cycle
//   later. FLUSH (branch redirect) discards everything held plus any beat
//   accepted in the same cycle. Bubbles never write the register file or
//   load the PC, because write_OUT / PC_load_OUT are gated by valid_OUT.
//
// Configuration macro:
//   DECODE_PIPE_SKID_EN
//     undefined : single entry; ready_OUT = !valid_OUT || ready_IN, so the
//                 ready path is combinational through the stage.
//     defined   : head plus skid entry; ready_OUT is a registered
//                 "skid slot empty" with no combinational path from ready_IN.
//
// Parameters:
//   ADDR_W      width of the register write address (default 3)
//   RESET_ADDR  value loaded into the write-address register on reset
//
// Ports:
//   CLK          in   stage clock, rising edge
//   RST          in   synchronous active-high reset
//   valid_IN     in   upstream beat present
//   ready_OUT    out  stage can accept a beat this cycle
//   writeAd_IN   in   [ADDR_W] destination register address
//   ADR_MUX_IN   in   address-mux control bit
//   write_IN     in   register-file write enable
//   PC_load_IN   in   PC load enable
//   FLUSH        in   discard held and incoming beats
//   valid_OUT    out  downstream beat present
//   ready_IN     in   downstream accepts the beat
//   writeAd_OUT  out  [ADDR_W] head-beat address (held while idle)
//   ADR_MUX_OUT  out  head-beat address-mux bit (held while idle)
//   write_OUT    out  head-beat write enable, 0 when no beat
//   PC_load_OUT  out  head-beat PC load, 0 when no beat
// ---------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int                ADDR_W     = 3,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_IN,
    output logic              ready_OUT,
    input  logic [ADDR_W-1:0] writeAd_IN,
    input  logic              ADR_MUX_IN,
    input  logic              write_IN,
    input  logic              PC_load_IN,
    input  logic              FLUSH,
    output logic              valid_OUT,
    input  logic              ready_IN,
    output logic [ADDR_W-1:0] writeAd_OUT,
    output logic              ADR_MUX_OUT,
    output logic              write_OUT,
    output logic              PC_load_OUT
);

    typedef struct packed {
        logic [ADDR_W-1:0] write_ad;
        logic              adr_mux;
        logic              write;
        logic              pc_load;
    } beat_t;

    localparam beat_t RESET_BEAT = '{
        write_ad: RESET_ADDR,
        adr_mux:  1'b0,
        write:    1'b0,
        pc_load:  1'b0
    };

    beat_t in_beat;
    beat_t head;
    logic  head_valid;
    logic  up_xfer;
    logic  down_xfer;

    assign in_beat = '{
        write_ad: writeAd_IN,
        adr_mux:  ADR_MUX_IN,
        write:    write_IN,
        pc_load:  PC_load_IN
    };

    // FLUSH deliberately does not gate ready_OUT: a beat that handshakes
    // during a flush is accepted upstream and then simply dropped.
    assign up_xfer   = valid_IN && ready_OUT;
    assign down_xfer = head_valid && ready_IN;

`ifdef DECODE_PIPE_SKID_EN

    beat_t skid;
    logic  skid_valid;

    // skid_valid is a flop, so ready_OUT has no combinational path from
    // ready_IN; the stage can always absorb one extra beat while stalled.
    assign ready_OUT = !skid_valid;

    // Head/skid update. The skid slot is only ever filled while the head is
    // held, and it drains into the head on the next downstream transfer.
    // The head payload is left untouched when the head empties so that the
    // address and mux bit stay stable across bubbles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= RESET_BEAT;
            skid       <= RESET_BEAT;
        end else if (FLUSH) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!head_valid) begin
            if (up_xfer) begin
                head       <= in_beat;
                head_valid <= 1'b1;
            end
        end else if (down_xfer) begin
            if (skid_valid) begin
                head       <= skid;
                skid_valid <= 1'b0;
            end else if (up_xfer) begin
                head <= in_beat;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (up_xfer) begin
            skid       <= in_beat;
            skid_valid <= 1'b1;
        end
    end

`else

    // Single entry: accept when empty or when the held beat leaves now.
    assign ready_OUT = !head_valid || ready_IN;

    // Single-entry head register. A simultaneous accept and consume
    // replaces the head in place, keeping valid_OUT high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_valid <= 1'b0;
            head       <= RESET_BEAT;
        end else if (FLUSH) begin
            head_valid <= 1'b0;
        end else if (up_xfer) begin
            head       <= in_beat;
            head_valid <= 1'b1;
        end else if (down_xfer) begin
            head_valid <= 1'b0;
        end
    end

`endif

    // Side-effecting controls are masked by valid so a bubble is harmless.
    assign valid_OUT   = head_valid;
    assign writeAd_OUT = head.write_ad;
    assign ADR_MUX_OUT = head.adr_mux;
    assign write_OUT   = head_valid && head.write;
    assign PC_load_OUT = head_valid && head.pc_load;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Purpose:
//   Self-checking bench for decode_pipe_stage built with ADDR_W=5 and
//   RESET_ADDR=31. Directed steps (streaming, stall, flush, bubble, reset
//   mid-stall, wide address) are followed by a randomized phase. Expected
//   outputs come from a FIFO model: a queue of beats whose capacity is 1,
//   or 2 when DECODE_PIPE_SKID_EN is defined.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    localparam int            AW = 5;
    localparam logic [AW-1:0] RA = 5'd31;
`ifdef DECODE_PIPE_SKID_EN
    localparam int CAP  = 2;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = 1;
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] wad;
        logic          adr;
        logic          wr;
        logic          pc;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          valid_IN = 1'b0;
    logic          ready_OUT;
    logic [AW-1:0] writeAd_IN = '0;
    logic          ADR_MUX_IN = 1'b0;
    logic          write_IN = 1'b0;
    logic          PC_load_IN = 1'b0;
    logic          FLUSH = 1'b0;
    logic          valid_OUT;
    logic          ready_IN = 1'b0;
    logic [AW-1:0] writeAd_OUT;
    logic          ADR_MUX_OUT;
    logic          write_OUT;
    logic          PC_load_OUT;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t modelQ[$];
    beat_t lastBeat;
    bit    modelKnown = 1'b0;

    always #5 CLK = ~CLK;

    decode_pipe_stage #(
        .ADDR_W     (AW),
        .RESET_ADDR (RA)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .valid_IN    (valid_IN),
        .ready_OUT   (ready_OUT),
        .writeAd_IN  (writeAd_IN),
        .ADR_MUX_IN  (ADR_MUX_IN),
        .write_IN    (write_IN),
        .PC_load_IN  (PC_load_IN),
        .FLUSH       (FLUSH),
        .valid_OUT   (valid_OUT),
        .ready_IN    (ready_IN),
        .writeAd_OUT (writeAd_OUT),
        .ADR_MUX_OUT (ADR_MUX_OUT),
        .write_OUT   (write_OUT),
        .PC_load_OUT (PC_load_OUT)
    );

    // Ready as seen from the FIFO model: room in the queue, or (without the
    // skid slot) the only entry is leaving this cycle.
    function automatic bit modelReady(input bit rdy);
        return (modelQ.size() < CAP) || (!SKID && rdy);
    endfunction

    task automatic checkOne(input string tag, input logic [AW-1:0] obs,
                            input logic [AW-1:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model state for the current cycle.
    task automatic checkOutput(input string step);
        beat_t e;
        bit    ev;
        if (modelKnown) begin
            ev = (modelQ.size() > 0);
            e  = ev ? modelQ[0] : lastBeat;
            checkOne({step, ".valid_OUT"},   AW'(valid_OUT),   AW'(ev));
            checkOne({step, ".ready_OUT"},   AW'(ready_OUT),   AW'(modelReady(ready_IN)));
            checkOne({step, ".writeAd_OUT"}, writeAd_OUT,      e.wad);
            checkOne({step, ".ADR_MUX_OUT"}, AW'(ADR_MUX_OUT), AW'(e.adr));
            checkOne({step, ".write_OUT"},   AW'(write_OUT),   AW'(ev && e.wr));
            checkOne({step, ".PC_load_OUT"}, AW'(PC_load_OUT), AW'(ev && e.pc));
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the
    // model on the rising edge.
    task automatic applyStimulus(input bit rst, input bit v, input logic [AW-1:0] wad,
                                 input bit adr, input bit wr, input bit pc,
                                 input bit fl, input bit rdy, input string step);
        bit    up;
        bit    down;
        beat_t inBeat;
        @(negedge CLK);
        RST        = rst;
        valid_IN   = v;
        writeAd_IN = wad;
        ADR_MUX_IN = adr;
        write_IN   = wr;
        PC_load_IN = pc;
        FLUSH      = fl;
        ready_IN   = rdy;
        #1;
        checkOutput(step);
        up     = v && modelReady(rdy);
        down   = (modelQ.size() > 0) && rdy;
        inBeat = '{wad: wad, adr: adr, wr: wr, pc: pc};
        @(posedge CLK);
        if (rst) begin
            modelQ.delete();
            lastBeat   = '{wad: RA, adr: 1'b0, wr: 1'b0, pc: 1'b0};
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            if (modelQ.size() > 0) lastBeat = modelQ[0];
            if (down) void'(modelQ.pop_front());
            if (fl) modelQ.delete();
            else if (up) modelQ.push_back(inBeat);
            if (modelQ.size() > 0) lastBeat = modelQ[0];
        end
    endtask

    initial begin
        // Reset and idle
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst0");
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst1");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

        // Streaming beats 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b1, AW'(i), i[0], 1'b1, 1'b0, 1'b0, 1'b1, "stream");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stream_end");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stream_idle");

        // Stall with beat 5 held and beat 6 pressing upstream
        applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "stall_load");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "stall");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stall_drain");

        // Flush with the stage full, then a fresh beat 7
        applyStimulus(1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fl_a");
        applyStimulus(1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fl_b");
        applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "flush");
        applyStimulus(1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_flush");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "beat7_out");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "flush_idle");

        // Bubble after a beat that writes and loads the PC
        applyStimulus(1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "bub_load");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bub_head");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bubble");

        // Reset while stalled with beats held
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rs_a");
        applyStimulus(1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rs_b");
        applyStimulus(1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rs_rst");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rs_rel");

        // Wide address passes unaltered
        applyStimulus(1'b0, 1'b1, 5'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "wide17");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "wide17_out");
        applyStimulus(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "wide_idle");

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 7,
                          AW'($urandom),
                          1'($urandom),
                          1'($urandom),
                          1'($urandom),
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 6,
                          "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameter ADDR_W, default 3, width of the register write address carried through the stage.
REQ-002 Parameter RESET_ADDR, default 0, value loaded into the write-address register on reset.
REQ-003 CLK  input  1  stage clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-005 valid_IN  input  1  upstream beat present.
REQ-006 ready_OUT  output  1  stage can accept a beat this cycle.
REQ-007 writeAd_IN  input  ADDR_W  destination register address.
REQ-008 ADR_MUX_IN, write_IN, PC_load_IN  input  1 each  control bits from decode.
REQ-009 FLUSH  input  1  discard all held and incoming beats (branch redirect).
REQ-010 valid_OUT  output  1  downstream beat present.
REQ-011 ready_IN  input  1  downstream accepts the beat.
REQ-012 writeAd_OUT  output  ADDR_W; ADR_MUX_OUT, write_OUT, PC_load_OUT  output  1 each; head-beat payload.

Function
REQ-013 Upstream transfer occurs when valid_IN && ready_OUT; downstream transfer occurs when valid_OUT && ready_IN.
REQ-014 A beat accepted in cycle N is presented on the outputs at cycle N+1 at the earliest (latency 1).
REQ-015 Beats leave in acceptance order; no beat is duplicated or dropped except by FLUSH or RST.
REQ-016 While valid_OUT=1 and ready_IN=0, all payload outputs hold stable.
REQ-017 write_OUT and PC_load_OUT are forced to 0 whenever valid_OUT=0, so a bubble never writes the register file or loads the PC.
REQ-018 writeAd_OUT and ADR_MUX_OUT keep their last value while valid_OUT=0.
REQ-019 Simultaneous upstream and downstream transfer with one beat held: the new beat replaces the head; valid_OUT stays 1.
REQ-020 FLUSH=1 in cycle N: every held beat and any beat accepted in cycle N is discarded; valid_OUT=0 at N+1.
REQ-021 FLUSH does not gate ready_OUT combinationally; a beat transferring during FLUSH counts as accepted upstream and is dropped.
REQ-022 A downstream transfer in the FLUSH cycle completes normally (the head beat is consumed, not recalled).

Reset
REQ-023 RST=1 at a rising edge: valid_OUT=0, skid slot empty, writeAd_OUT=RESET_ADDR, ADR_MUX_OUT=0, write_OUT=0, PC_load_OUT=0.
REQ-024 ready_OUT=1 in the first cycle after reset is released.
REQ-025 RST has priority over FLUSH and over any transfer in the same cycle; a beat presented during RST is lost.
REQ-026 Reset asserted mid-stall clears held beats identically to REQ-023.

Configuration
REQ-027 Macro DECODE_PIPE_SKID_EN selects the ready path.
REQ-028 Without DECODE_PIPE_SKID_EN: single entry; ready_OUT = !valid_OUT || ready_IN (combinational through the stage).
REQ-029 With DECODE_PIPE_SKID_EN: two entries (head plus skid); ready_OUT is a flop equal to "skid slot empty", with no combinational path from ready_IN.
REQ-030 With DECODE_PIPE_SKID_EN, a beat accepted while the head is held and not consumed goes to the skid slot; it moves to the head on the next downstream transfer, and ready_OUT returns to 1 the cycle after.
REQ-031 Both builds are cycle-identical whenever ready_IN=1 continuously.

Verification
REQ-032 Streaming: beats with writeAd 1,2,3,4, ready_IN=1 -> outputs 1,2,3,4 on consecutive cycles, one cycle after each input.
REQ-033 Stall: hold ready_IN=0 for 3 cycles with beat writeAd=5, write=1 -> outputs stable at 5/1; SKID build accepts exactly one more beat, then ready_OUT=0; the non-SKID build shows ready_OUT=0 immediately.
REQ-034 Flush: two beats held (SKID build), FLUSH pulsed for 1 cycle -> valid_OUT=0 and write_OUT=0 next cycle; the following beat writeAd=7 appears normally.
REQ-035 Bubble gating: valid_IN=1 with write_IN=1, PC_load_IN=1, then valid_IN=0 -> write_OUT=PC_load_OUT=0 in the bubble cycle, while writeAd_OUT retains the previous value.
REQ-036 Reset mid-stall: RST asserted with two held beats -> all outputs at reset values next cycle; ready_OUT=1 after RST is released.
REQ-037 ADDR_W=5, RESET_ADDR=31: reset gives writeAd_OUT=31; beat writeAd=17 passes unaltered.
